// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the multi-digit up/down counter.
package cnt_pkg;

  localparam logic CNT_UP = 1'b0;
  localparam logic CNT_DN = 1'b1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cnt_digit.sv
// One radix-BASE counter digit with clamped parallel load and wrap on step.
module cnt_digit
  import cnt_pkg::*;
#(
  parameter  int BASE = 10,
  localparam int W    = clog2_min1(BASE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [W-1:0] MAXV = W'(BASE - 1);
  localparam logic [W:0]   LIMV = (W + 1)'(BASE);

  logic [W-1:0] d_clamped;

  assign d_clamped = ({1'b0, d_in} >= LIMV) ? MAXV : d_in;
  assign at_max    = (q == MAXV);
  assign at_min    = (q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d_clamped;
    end else if (step) begin
      if (dir == CNT_UP) q <= at_max ? '0 : q + 1'b1;
      else               q <= at_min ? MAXV : q - 1'b1;
    end
  end

endmodule

// File: rtl/cnt_ndigit_ud.sv
// DIGITS cascaded radix-BASE digits forming an up/down counter with load,
// wrap/saturate mode, combinational terminal count and sticky overflow.
module cnt_ndigit_ud
  import cnt_pkg::*;
#(
  parameter  int DIGITS = 2,
  parameter  int BASE   = 10,
  localparam int W      = clog2_min1(BASE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                dir,
  input  logic                sat,
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_val,
  output logic [DIGITS*W-1:0] cntQ,
  output logic                tc,
  output logic                ovf
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] pfx;
  logic [DIGITS-1:0] step;
  logic              term;
  logic              hold;

  assign term = (dir == CNT_DN) ? (&at_min) : (&at_max);
  assign tc   = term & en;
  assign hold = sat & term;

  // Digit i may step only when every lower digit sits at its rollover value.
  always_comb begin
    pfx    = '0;
    pfx[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      pfx[i] = pfx[i-1] & ((dir == CNT_DN) ? at_min[i-1] : at_max[i-1]);
    end
  end

  assign step = {DIGITS{en & ~hold}} & pfx;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    cnt_digit #(.BASE(BASE)) u_digit (
      .clk    (clk),
      .reset  (reset),
      .step   (step[g]),
      .dir    (dir),
      .load   (load),
      .d_in   (load_val[g*W +: W]),
      .q      (cntQ[g*W +: W]),
      .at_max (at_max[g]),
      .at_min (at_min[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || load) ovf <= 1'b0;
    else if (tc)       ovf <= 1'b1;
  end

endmodule

// File: tb/tb_cnt_ndigit_ud.sv
// Directed bench for cnt_ndigit_ud: a 2-digit decimal and a 3-digit hex instance.
module tb_cnt_ndigit_ud;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Decimal, two digits
  logic       reset, en, dir, sat, load;
  logic [7:0] load_val;
  logic [7:0] cntQ;
  logic       tc, ovf;

  cnt_ndigit_ud #(.DIGITS(2), .BASE(10)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .cntQ(cntQ), .tc(tc), .ovf(ovf)
  );

  // Hex, three digits
  logic        reset3, en3, dir3, sat3, load3;
  logic [11:0] load_val3;
  logic [11:0] cntQ3;
  logic        tc3, ovf3;

  cnt_ndigit_ud #(.DIGITS(3), .BASE(16)) dut3 (
    .clk(clk), .reset(reset3), .en(en3), .dir(dir3), .sat(sat3), .load(load3),
    .load_val(load_val3), .cntQ(cntQ3), .tc(tc3), .ovf(ovf3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] exp3;

  initial begin
    reset = 1'b1; en = 1'b1; dir = 1'b0; sat = 1'b0; load = 1'b0; load_val = 8'h00;
    reset3 = 1'b1; en3 = 1'b0; dir3 = 1'b0; sat3 = 1'b0; load3 = 1'b0; load_val3 = 12'h000;

    // Reset held two edges with en=1
    tick();
    chk("reset_cnt", 32'(cntQ), 32'h00);
    chk("reset_ovf", 32'(ovf), 32'h0);
    tick();
    chk("reset_tc", 32'(tc), 32'h0);
    reset = 1'b0;

    // Up count to 99, then wrap
    for (int i = 0; i < 99; i++) tick();
    chk("up_99_cnt", 32'(cntQ), 32'h99);
    chk("up_99_tc", 32'(tc), 32'h1);
    chk("up_99_ovf", 32'(ovf), 32'h0);
    tick();
    chk("wrap_cnt", 32'(cntQ), 32'h00);
    chk("wrap_ovf", 32'(ovf), 32'h1);
    chk("wrap_tc", 32'(tc), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ovf_sticky", 32'(ovf), 32'h1);
    end
    chk("after5_cnt", 32'(cntQ), 32'h05);

    // Load 01, count down with saturation
    load = 1'b1; en = 1'b0; load_val = 8'h01;
    tick();
    chk("load01_cnt", 32'(cntQ), 32'h01);
    chk("load01_ovf", 32'(ovf), 32'h0);
    load = 1'b0; en = 1'b1; dir = 1'b1; sat = 1'b1;
    tick();
    chk("dn_00_cnt", 32'(cntQ), 32'h00);
    chk("dn_00_tc", 32'(tc), 32'h1);
    chk("dn_00_ovf", 32'(ovf), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_hold_cnt", 32'(cntQ), 32'h00);
      chk("sat_hold_ovf", 32'(ovf), 32'h1);
    end
    en = 1'b0;
    #1;
    chk("tc_needs_en", 32'(tc), 32'h0);

    // Clamp on load, load beats en
    load = 1'b1; en = 1'b1; dir = 1'b0; sat = 1'b0; load_val = 8'h3F;
    tick();
    chk("clamp_cnt", 32'(cntQ), 32'h39);
    chk("clamp_ovf", 32'(ovf), 32'h0);
    load = 1'b0;
    tick();
    chk("clamp_step", 32'(cntQ), 32'h40);

    // Direction change mid-count
    load = 1'b1; load_val = 8'h18;
    tick();
    chk("load18", 32'(cntQ), 32'h18);
    load = 1'b0;
    tick(); chk("dc_up1", 32'(cntQ), 32'h19);
    tick(); chk("dc_up2", 32'(cntQ), 32'h20);
    tick(); chk("dc_up3", 32'(cntQ), 32'h21);
    dir = 1'b1;
    tick(); chk("dc_dn1", 32'(cntQ), 32'h20);
    tick(); chk("dc_dn2", 32'(cntQ), 32'h19);

    // Saturate at the up terminal
    load = 1'b1; load_val = 8'h99;
    tick();
    load = 1'b0; dir = 1'b0; sat = 1'b1;
    #1;
    chk("satup_tc", 32'(tc), 32'h1);
    tick();
    chk("satup_cnt", 32'(cntQ), 32'h99);
    chk("satup_ovf", 32'(ovf), 32'h1);

    // Down wrap from 00 with sat=0
    load = 1'b1; load_val = 8'h00;
    tick();
    load = 1'b0; dir = 1'b1; sat = 1'b0;
    tick();
    chk("dnwrap_cnt", 32'(cntQ), 32'h99);
    chk("dnwrap_ovf", 32'(ovf), 32'h1);

    // Reset beats load
    reset = 1'b1; load = 1'b1; load_val = 8'h55;
    tick();
    chk("rst_vs_load", 32'(cntQ), 32'h00);
    chk("rst_vs_load_ovf", 32'(ovf), 32'h0);
    reset = 1'b0; load = 1'b0; en = 1'b0;
    tick();
    chk("hold_en0", 32'(cntQ), 32'h00);

    // Hex 3-digit sweep through a full wrap
    tick();
    reset3 = 1'b0; en3 = 1'b1;
    chk("hex_reset", 32'(cntQ3), 32'h000);
    exp3 = 12'h000;
    for (int i = 0; i < 4096; i++) begin
      chk("hex_tc", 32'(tc3), (i == 4095) ? 32'h1 : 32'h0);
      tick();
      exp3 = exp3 + 12'h001;
      chk("hex_cnt", 32'(cntQ3), 32'(exp3));
    end
    chk("hex_final_cnt", 32'(cntQ3), 32'h000);
    chk("hex_final_ovf", 32'(ovf3), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnt_ndigit_ud.md
# cnt_ndigit_ud

Parametrised multi-digit up/down counter, the successor to the fixed 4-bit modulo-10 reversible counter. It chains DIGITS cells of radix BASE, for example decimal, octal or hex digits. Each cell wraps at BASE-1/0 and carries or borrows into the next cell. Adds count enable, parallel load, a wrap/saturate mode, a terminal-count flag and a sticky overflow flag. It drives display/timer logic as a general-purpose event counter.

## Interface
- DIGITS, 2, number of cascaded digit cells (≥1)
- BASE, 10, radix of every digit (2..16)
- W, $clog2(BASE), derived digit width (localparam, not overridable)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable; one step per enabled edge
- dir  input  1  0 = count up, 1 = count down
- sat  input  1  0 = wrap at terminal, 1 = hold at terminal
- load  input  1  synchronous parallel load
- load_val  input  DIGITS*W  load value; digit i occupies [i*W +: W], digit 0 is least significant
- cntQ  output  DIGITS*W  registered count, same packing as load_val
- tc  output  1  terminal count, combinational
- ovf  output  1  sticky overflow/underflow flag, registered

## Operation
- Priority per edge: reset > load > en > hold.
- reset: cntQ = 0, ovf = 0.
- load: digit i takes load_val digit i. Any loaded digit ≥ BASE is clamped to BASE-1. ovf is cleared. en is ignored in that cycle.
- Up step: digit 0 increments. Digit i steps only when all lower digits are at BASE-1. A digit at BASE-1 that steps becomes 0.
- Down step: digit 0 decrements. Digit i steps only when all lower digits are 0. A digit at 0 that steps becomes BASE-1.
- Terminal state: every digit at BASE-1 when dir=0; every digit at 0 when dir=1.
- tc = terminal state (for the current dir) AND en. It does not depend on sat.
- At the terminal state with en=1:
  - sat=0: the counter wraps (up to all zeros, down to all BASE-1). ovf sets on the same edge.
  - sat=1: cntQ holds and ovf sets on the same edge.
- ovf stays at 1 until reset or load.
- dir, sat and en are sampled every edge. A direction change applies to the next enabled edge, with no dead cycle.
- Digit values ≥ BASE are unreachable except by load, and load clamps them.

## Timing
- cntQ and ovf: 1-cycle latency from the sampled en/load/reset edge.
- tc: zero latency; it is combinational from the cntQ register, dir and en. It is glitch-tolerant only at the clock edge.
- Cascade carry is combinational across digits within one cycle. The critical path is DIGITS digit comparators; DIGITS ≤ 8 must close timing at the module clock.
- Reset mid-count with en=1: cntQ = 0 on that edge; counting resumes from 0 on the next enabled edge after reset falls.
- Reset and load together: reset wins. Load and en together: load wins with no step.

## Structure
- Package cnt_pkg: function clog2_min1 (returns at least 1), plus constants for the dir encodings CNT_UP = 0 and CNT_DN = 1.
- Sub-module cnt_digit:
  - Inputs: clk, reset, step, dir, load, d_in.
  - Outputs: q, at_max, at_min.
  - Parameter: BASE.
- The top generates DIGITS instances of cnt_digit. Each instance's step is en AND the prefix AND of lower at_max (up) or at_min (down), gated off when sat and terminal state.
- Terminal and ovf logic live in the top.

## Test plan
- Reset: DIGITS=2, BASE=10. Assert reset for 2 edges with en=1, dir=0 -> cntQ = 8'h00 and ovf = 0 on the first edge; tc = 0.
- Up wrap: from 00, en=1, dir=0, sat=0.
  - After 99 edges: cntQ = 8'h99 and tc = 1.
  - Next edge: cntQ = 8'h00 and ovf = 1.
  - ovf stays 1 through 5 more steps.
- Down and saturate: load 8'h01, then en=1, dir=1, sat=1.
  - One edge -> 8'h00 with tc = 1.
  - Next 3 edges -> cntQ stays 8'h00 and ovf = 1.
- Load clamp and priority: load=1, en=1, load_val = 8'h3F -> cntQ = 8'h39, ovf cleared, no step that cycle. Then 1 up step -> 8'h40.
- Mid-count direction change: from 8'h18 with en=1, dir=0 for 3 edges -> 8'h21. Then dir=1 for 2 edges -> 8'h19. Each edge's value is checked.
- Radix sweep: DIGITS=3, BASE=16 (W=4). Count up 4096 edges from 0 -> cntQ = 12'h000 and ovf = 1, with tc high only on the edge at 12'hFFF.
